// File: rtl/sdaccel_ctrl_pkg.sv
// Shared constants for the SDAccel ap_ctrl_hs control-register slave.
// Register word selects, CTRL/IER/ISR bit positions and the AXI OKAY response.
package sdaccel_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte offset of arg 0; everything below it is the control block.
    localparam int unsigned ADDR_ARG_BASE = 32'h10;
    localparam int unsigned ARG_BASE_WORD = ADDR_ARG_BASE / 4;

    // Word selects of the control block (byte offsets 0x00, 0x04, 0x08, 0x0C).
    typedef enum logic [1:0] {
        RegCtrl = 2'd0,
        RegGie  = 2'd1,
        RegIer  = 2'd2,
        RegIsr  = 2'd3
    } low_reg_e;

    localparam int unsigned CTRL_AP_START     = 0;
    localparam int unsigned CTRL_DONE         = 1;
    localparam int unsigned CTRL_IDLE         = 2;
    localparam int unsigned CTRL_READY        = 3;
    localparam int unsigned CTRL_AUTO_RESTART = 7;

    localparam int unsigned IRQ_DONE  = 0;
    localparam int unsigned IRQ_READY = 1;

    function automatic logic [31:0] ctrl_word(input logic start, input logic done,
                                              input logic idle, input logic ready,
                                              input logic auto_restart);
        logic [31:0] w;
        w                    = '0;
        w[CTRL_AP_START]     = start;
        w[CTRL_DONE]         = done;
        w[CTRL_IDLE]         = idle;
        w[CTRL_READY]        = ready;
        w[CTRL_AUTO_RESTART] = auto_restart;
        return w;
    endfunction

endpackage

// File: rtl/sdaccel_ap_ctrl.sv
// ap_ctrl_hs state: ap_start, auto_restart, done/ready sticky bits and the
// optional interrupt block (GIE/IER/ISR), enabled by SDACCEL_CTRL_IRQ_EN.
module sdaccel_ap_ctrl
    import sdaccel_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_sel_i,
    input  logic [7:0]  wdata_i,
    input  logic        rd_en_i,
    input  logic [1:0]  rd_sel_i,
    input  logic        ap_ready_i,
    input  logic        ap_done_i,
    input  logic        ap_idle_i,
    output logic        ap_start_o,
    output logic [31:0] rdata_o,
    output logic        interrupt_o
);

    logic start_q, start_d, auto_q, auto_d;
    logic done_q, done_d, rdy_q, rdy_d;
    logic ctrl_wr, ctrl_rd;
    logic       irq_gie;
    logic [1:0] irq_ier, irq_isr;
    logic       unused_wdata;

    assign ctrl_wr      = wr_en_i && (wr_sel_i == RegCtrl);
    assign ctrl_rd      = rd_en_i && (rd_sel_i == RegCtrl);
    assign unused_wdata = ^wdata_i[6:1];

    // Next state of start/auto_restart and the clear-on-read sticky bits (set wins).
    always_comb begin
        start_d = start_q;
        auto_d  = auto_q;
        if (ap_ready_i && !auto_q) start_d = 1'b0;
        if (ctrl_wr) begin
            if (wdata_i[CTRL_AP_START]) start_d = 1'b1;
            auto_d = wdata_i[CTRL_AUTO_RESTART];
        end
        done_d = ap_done_i  | (done_q & ~ctrl_rd);
        rdy_d  = ap_ready_i | (rdy_q  & ~ctrl_rd);
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            start_q <= start_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef SDACCEL_CTRL_IRQ_EN
    logic       gie_q, gie_d, irq_q, irq_d;
    logic [1:0] ier_q, ier_d, isr_q, isr_d;

    // Interrupt registers; an enabled event beats a same-cycle ISR toggle.
    always_comb begin
        gie_d = gie_q;
        ier_d = ier_q;
        isr_d = isr_q;
        if (wr_en_i && (wr_sel_i == RegGie)) gie_d = wdata_i[0];
        if (wr_en_i && (wr_sel_i == RegIer)) ier_d = wdata_i[1:0];
        if (wr_en_i && (wr_sel_i == RegIsr)) isr_d = isr_q ^ wdata_i[1:0];
        if (ap_done_i  && ier_q[IRQ_DONE])  isr_d[IRQ_DONE]  = 1'b1;
        if (ap_ready_i && ier_q[IRQ_READY]) isr_d[IRQ_READY] = 1'b1;
        irq_d = gie_d & (|isr_d);
    end

    // Interrupt state register; the output is registered from next-state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie_q <= 1'b0;
            ier_q <= 2'b00;
            isr_q <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            gie_q <= gie_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end

    assign irq_gie     = gie_q;
    assign irq_ier     = ier_q;
    assign irq_isr     = isr_q;
    assign interrupt_o = irq_q;
`else
    assign irq_gie     = 1'b0;
    assign irq_ier     = 2'b00;
    assign irq_isr     = 2'b00;
    assign interrupt_o = 1'b0;
`endif

    assign ap_start_o = start_q;

    // Read mux for the control block.
    always_comb begin
        rdata_o = '0;
        unique case (rd_sel_i)
            RegCtrl: rdata_o = ctrl_word(start_q, done_q, ap_idle_i, rdy_q, auto_q);
            RegGie:  rdata_o = {31'b0, irq_gie};
            RegIer:  rdata_o = {30'b0, irq_ier};
            RegIsr:  rdata_o = {30'b0, irq_isr};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/sdaccel_ctrl_regfile.sv
// AXI4-Lite control slave for SDAccel kernels: write/read channels and the
// argument registers. Optional interrupt block under SDACCEL_CTRL_IRQ_EN.
module sdaccel_ctrl_regfile
    import sdaccel_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ARGS = 4,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_AWVALID,
    output logic                     csr_AWREADY,
    input  logic [ADDR_W-1:0]        csr_AWADDR,
    input  logic                     csr_WVALID,
    output logic                     csr_WREADY,
    input  logic [31:0]              csr_WDATA,
    input  logic [3:0]               csr_WSTRB,
    output logic                     csr_BVALID,
    input  logic                     csr_BREADY,
    output logic [1:0]               csr_BRESP,
    input  logic                     csr_ARVALID,
    output logic                     csr_ARREADY,
    input  logic [ADDR_W-1:0]        csr_ARADDR,
    output logic                     csr_RVALID,
    input  logic                     csr_RREADY,
    output logic [31:0]              csr_RDATA,
    output logic [1:0]               csr_RRESP,
    output logic                     ap_start,
    input  logic                     ap_ready,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    output logic [32*NUM_ARGS-1:0]   args,
    output logic                     interrupt
);

    localparam int unsigned IW = ADDR_W - 2;

    logic                       init_q;
    logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]              aw_word_q, aw_word_d;
    logic [31:0]                w_data_q, w_data_d;
    logic [3:0]                 w_strb_q, w_strb_d;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [31:0]                rdata_q, rdata_d, rd_mux, ctrl_rdata;
    logic [NUM_ARGS-1:0][31:0]  args_q, args_d;
    logic                       aw_hs, w_hs, ar_hs, commit;
    logic [31:0]                wr_word, rd_word;
    logic                       unused_addr;

    // READYs stay low until the first edge after reset releases (init_q).
    assign csr_AWREADY = init_q && !aw_held_q && !bvalid_q;
    assign csr_WREADY  = init_q && !w_held_q && !bvalid_q;
    assign csr_ARREADY = init_q && !rvalid_q;
    assign csr_BVALID  = bvalid_q;
    assign csr_RVALID  = rvalid_q;
    assign csr_RDATA   = rdata_q;
    assign csr_BRESP   = RESP_OKAY;
    assign csr_RRESP   = RESP_OKAY;
    assign args        = args_q;

    assign aw_hs   = csr_AWVALID && csr_AWREADY;
    assign w_hs    = csr_WVALID && csr_WREADY;
    assign ar_hs   = csr_ARVALID && csr_ARREADY;
    assign commit  = aw_held_q && w_held_q;
    assign wr_word = 32'(aw_word_q);
    assign rd_word = 32'(csr_ARADDR[ADDR_W-1:2]);
    assign unused_addr = ^{csr_AWADDR[1:0], csr_ARADDR[1:0]};

    sdaccel_ap_ctrl u_ap_ctrl (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (commit && (wr_word < ARG_BASE_WORD) && w_strb_q[0]),
        .wr_sel_i    (aw_word_q[1:0]),
        .wdata_i     (w_data_q[7:0]),
        .rd_en_i     (ar_hs && (rd_word < ARG_BASE_WORD)),
        .rd_sel_i    (csr_ARADDR[3:2]),
        .ap_ready_i  (ap_ready),
        .ap_done_i   (ap_done),
        .ap_idle_i   (ap_idle),
        .ap_start_o  (ap_start),
        .rdata_o     (ctrl_rdata),
        .interrupt_o (interrupt)
    );

    // Read decode; unmapped words return 0.
    always_comb begin
        rd_mux = '0;
        if (rd_word < ARG_BASE_WORD) rd_mux = ctrl_rdata;
        for (int k = 0; k < int'(NUM_ARGS); k++) begin
            if (rd_word == ARG_BASE_WORD + k) rd_mux = args_q[k];
        end
    end

    // Channel next-state: holding registers, commit, B and R handshakes.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_word_d = aw_word_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_word_d = csr_AWADDR[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = csr_WDATA;
            w_strb_d = csr_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && csr_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && csr_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q    <= 1'b0;
            aw_held_q <= 1'b0;
            aw_word_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            init_q    <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_word_q <= aw_word_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Byte-strobed argument register writes at commit.
    always_comb begin
        args_d = args_q;
        if (commit) begin
            for (int k = 0; k < int'(NUM_ARGS); k++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((wr_word == ARG_BASE_WORD + k) && w_strb_q[b]) begin
                        args_d[k][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Argument register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) args_q <= '0;
        else       args_q <= args_d;
    end

endmodule

// File: tb/tb_sdaccel_ctrl_regfile.sv
// Self-checking bench for sdaccel_ctrl_regfile (NUM_ARGS=4, ADDR_W=12).
// Interrupt checks follow SDACCEL_CTRL_IRQ_EN.
module tb_sdaccel_ctrl_regfile;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         csr_AWVALID = 1'b0, csr_AWREADY;
    logic [11:0]  csr_AWADDR = '0;
    logic         csr_WVALID = 1'b0, csr_WREADY;
    logic [31:0]  csr_WDATA = '0;
    logic [3:0]   csr_WSTRB = '0;
    logic         csr_BVALID, csr_BREADY = 1'b0;
    logic [1:0]   csr_BRESP;
    logic         csr_ARVALID = 1'b0, csr_ARREADY;
    logic [11:0]  csr_ARADDR = '0;
    logic         csr_RVALID, csr_RREADY = 1'b0;
    logic [31:0]  csr_RDATA;
    logic [1:0]   csr_RRESP;
    logic         ap_start, ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b0;
    logic [127:0] args;
    logic         interrupt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdaccel_ctrl_regfile #(.NUM_ARGS(4), .ADDR_W(12)) dut (
        .clk (clk), .reset (reset),
        .csr_AWVALID (csr_AWVALID), .csr_AWREADY (csr_AWREADY), .csr_AWADDR (csr_AWADDR),
        .csr_WVALID (csr_WVALID), .csr_WREADY (csr_WREADY), .csr_WDATA (csr_WDATA),
        .csr_WSTRB (csr_WSTRB), .csr_BVALID (csr_BVALID), .csr_BREADY (csr_BREADY),
        .csr_BRESP (csr_BRESP), .csr_ARVALID (csr_ARVALID), .csr_ARREADY (csr_ARREADY),
        .csr_ARADDR (csr_ARADDR), .csr_RVALID (csr_RVALID), .csr_RREADY (csr_RREADY),
        .csr_RDATA (csr_RDATA), .csr_RRESP (csr_RRESP), .ap_start (ap_start),
        .ap_ready (ap_ready), .ap_done (ap_done), .ap_idle (ap_idle), .args (args),
        .interrupt (interrupt)
    );

    typedef struct {
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic aw_done, w_done, aw_fire, w_fire;
        int   cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        csr_AWADDR  = addr;
        csr_WDATA   = data;
        csr_WSTRB   = strb;
        csr_AWVALID = 1'b1;
        csr_WVALID  = 1'b1;
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_fire = csr_AWVALID && csr_AWREADY;
            w_fire  = csr_WVALID && csr_WREADY;
            tick();
            if (aw_fire) begin aw_done = 1'b1; csr_AWVALID = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; csr_WVALID  = 1'b0; end
            cyc++;
        end
        csr_AWVALID = 1'b0;
        csr_WVALID  = 1'b0;
        check("write addr/data accept", {31'b0, aw_done && w_done}, 32'd1);
        cyc = 0;
        while (!csr_BVALID && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bvalid", {31'b0, csr_BVALID}, 32'd1);
        check("bresp", {30'b0, csr_BRESP}, 32'd0);
        csr_BREADY = 1'b1;
        tick();
        csr_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
        logic fired;
        int   cyc;
        fired = 1'b0;
        csr_ARADDR  = addr;
        csr_ARVALID = 1'b1;
        cyc = 0;
        while (!fired && cyc < 20) begin
            fired = csr_ARREADY;
            tick();
            cyc++;
        end
        csr_ARVALID = 1'b0;
        check("read addr accept", {31'b0, fired}, 32'd1);
        check("rvalid after ar", {31'b0, csr_RVALID}, 32'd1);
        check("arready while rvalid", {31'b0, csr_ARREADY}, 32'd0);
        check("rresp", {30'b0, csr_RRESP}, 32'd0);
        data = csr_RDATA;
        csr_RREADY = 1'b1;
        tick();
        csr_RREADY = 1'b0;
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0] = '{12'h014, 32'hDEADBEEF, 4'b0011, 12'h014, 32'h0000BEEF};
        vecs[1] = '{12'h010, 32'h12345678, 4'b1111, 12'h010, 32'h12345678};
        vecs[2] = '{12'h018, 32'hA5A5A5A5, 4'b1100, 12'h018, 32'hA5A50000};
        vecs[3] = '{12'h01C, 32'hCAFEF00D, 4'b1001, 12'h01C, 32'hCA00000D};
        vecs[4] = '{12'h017, 32'h11223344, 4'b0100, 12'h014, 32'h0022BEEF};
        vecs[5] = '{12'h200, 32'hFFFFFFFF, 4'b1111, 12'h200, 32'h00000000};
        vecs[6] = '{12'h020, 32'hFFFFFFFF, 4'b1111, 12'h020, 32'h00000000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("awready in reset", {31'b0, csr_AWREADY}, 32'd0);
        check("wready in reset", {31'b0, csr_WREADY}, 32'd0);
        check("arready in reset", {31'b0, csr_ARREADY}, 32'd0);
        reset = 1'b0;
        check("awready before first edge", {31'b0, csr_AWREADY}, 32'd0);
        tick();
        check("awready after reset", {31'b0, csr_AWREADY}, 32'd1);
        check("wready after reset", {31'b0, csr_WREADY}, 32'd1);
        check("arready after reset", {31'b0, csr_ARREADY}, 32'd1);
        check("bvalid reset", {31'b0, csr_BVALID}, 32'd0);
        check("rvalid reset", {31'b0, csr_RVALID}, 32'd0);
        check("rdata reset", csr_RDATA, 32'd0);
        check("ap_start reset", {31'b0, ap_start}, 32'd0);
        check("interrupt reset", {31'b0, interrupt}, 32'd0);
        check("args reset", {31'b0, |args}, 32'd0);

        // Table-driven write/read-back.
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            axi_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
        end
        check("args arg0", args[31:0], 32'h12345678);
        check("args arg1", args[63:32], 32'h0022BEEF);
        check("args arg2", args[95:64], 32'hA5A50000);
        check("args arg3", args[127:96], 32'hCA00000D);

        // W two cycles ahead of AW, then B back-pressure.
        csr_WDATA = 32'h0BADF00D;
        csr_WSTRB = 4'hF;
        csr_WVALID = 1'b1;
        tick();
        csr_WVALID = 1'b0;
        check("wready while w held", {31'b0, csr_WREADY}, 32'd0);
        check("bvalid w only", {31'b0, csr_BVALID}, 32'd0);
        tick();
        check("bvalid w only 2", {31'b0, csr_BVALID}, 32'd0);
        csr_AWADDR = 12'h010;
        csr_AWVALID = 1'b1;
        tick();
        csr_AWVALID = 1'b0;
        check("bvalid at aw handshake", {31'b0, csr_BVALID}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bvalid held", {31'b0, csr_BVALID}, 32'd1);
            check("awready during b", {31'b0, csr_AWREADY}, 32'd0);
            check("wready during b", {31'b0, csr_WREADY}, 32'd0);
            tick();
        end
        csr_BREADY = 1'b1;
        tick();
        csr_BREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("single bvalid", {31'b0, csr_BVALID}, 32'd0);
            tick();
        end
        axi_read(12'h010, rd);
        check("arg0 after split write", rd, 32'h0BADF00D);

        // Start/ready/done handshake.
        axi_write(12'h000, 32'h1, 4'hF);
        check("ap_start set", {31'b0, ap_start}, 32'd1);
        ap_ready = 1'b1;
        check("ap_start before ready edge", {31'b0, ap_start}, 32'd1);
        tick();
        ap_ready = 1'b0;
        check("ap_start cleared by ready", {31'b0, ap_start}, 32'd0);
        pulse_done();
        axi_read(12'h000, rd);
        check("ctrl done+ready", rd, 32'h0000000A);
        axi_read(12'h000, rd);
        check("ctrl cleared on read", rd, 32'h00000000);

        // Auto-restart keeps ap_start high.
        ap_idle = 1'b1;
        axi_write(12'h000, 32'h81, 4'hF);
        for (int i = 0; i < 3; i++) begin
            pulse_ready();
            check("auto_restart start", {31'b0, ap_start}, 32'd1);
            tick();
        end
        axi_read(12'h000, rd);
        check("ctrl auto+idle", rd, 32'h0000008D);
        ap_idle = 1'b0;
        axi_write(12'h000, 32'h0, 4'hF);
        check("write 0 keeps start", {31'b0, ap_start}, 32'd1);
        pulse_ready();
        check("start cleared after auto off", {31'b0, ap_start}, 32'd0);
        axi_read(12'h000, rd);
        check("ctrl ready only", rd, 32'h00000008);

        // ap_ready on the same edge as a CTRL start write.
        csr_AWADDR = 12'h000;
        csr_WDATA = 32'h1;
        csr_WSTRB = 4'hF;
        csr_AWVALID = 1'b1;
        csr_WVALID = 1'b1;
        tick();
        csr_AWVALID = 1'b0;
        csr_WVALID = 1'b0;
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        check("bvalid concurrent", {31'b0, csr_BVALID}, 32'd1);
        check("start wins over ready", {31'b0, ap_start}, 32'd1);
        csr_BREADY = 1'b1;
        tick();
        csr_BREADY = 1'b0;
        axi_read(12'h000, rd);
        check("ctrl start+ready", rd, 32'h00000009);
        pulse_ready();

        // ap_done in the CTRL read handshake cycle: pre-clear data, bit survives.
        csr_ARADDR = 12'h000;
        csr_ARVALID = 1'b1;
        ap_done = 1'b1;
        check("arready idle", {31'b0, csr_ARREADY}, 32'd1);
        tick();
        csr_ARVALID = 1'b0;
        ap_done = 1'b0;
        check("rvalid concurrent", {31'b0, csr_RVALID}, 32'd1);
        check("ctrl pre-clear value", csr_RDATA, 32'h00000008);
        csr_RREADY = 1'b1;
        tick();
        csr_RREADY = 1'b0;
        axi_read(12'h000, rd);
        check("done set wins over clear", rd, 32'h00000002);
        axi_read(12'h000, rd);
        check("ctrl empty", rd, 32'h00000000);

`ifdef SDACCEL_CTRL_IRQ_EN
        axi_write(12'h004, 32'h1, 4'hF);
        axi_write(12'h008, 32'h1, 4'hF);
        axi_read(12'h004, rd);
        check("gie readback", rd, 32'h1);
        axi_read(12'h008, rd);
        check("ier readback", rd, 32'h1);
        pulse_ready();
        check("masked ready no irq", {31'b0, interrupt}, 32'd0);
        pulse_done();
        check("interrupt on done", {31'b0, interrupt}, 32'd1);
        axi_read(12'h00C, rd);
        check("isr done", rd, 32'h1);
        axi_write(12'h00C, 32'h1, 4'hF);
        check("interrupt after isr toggle", {31'b0, interrupt}, 32'd0);
        axi_read(12'h00C, rd);
        check("isr cleared", rd, 32'h0);
`else
        axi_write(12'h004, 32'h1, 4'hF);
        axi_write(12'h008, 32'h3, 4'hF);
        axi_read(12'h004, rd);
        check("gie absent", rd, 32'h0);
        axi_read(12'h008, rd);
        check("ier absent", rd, 32'h0);
        pulse_done();
        check("interrupt tied low", {31'b0, interrupt}, 32'd0);
        axi_read(12'h00C, rd);
        check("isr absent", rd, 32'h0);
`endif

        // Reset while AW is held: the transaction is dropped.
        csr_AWADDR = 12'h010;
        csr_AWVALID = 1'b1;
        tick();
        csr_AWVALID = 1'b0;
        check("awready while aw held", {31'b0, csr_AWREADY}, 32'd0);
        reset = 1'b1;
        #1;
        check("bvalid in reset", {31'b0, csr_BVALID}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("args cleared by reset", args[31:0], 32'h0);
        csr_WDATA = 32'hFFFFFFFF;
        csr_WSTRB = 4'hF;
        csr_WVALID = 1'b1;
        tick();
        csr_WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("no bvalid after reset", {31'b0, csr_BVALID}, 32'd0);
            tick();
        end
        check("arg0 untouched", args[31:0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdaccel_ctrl_regfile.md
# sdaccel_ctrl_regfile

Parametrised AXI4-Lite control-register slave for SDAccel kernels. It implements the `ap_ctrl_hs` start/done/idle/ready handshake, an auto-restart mode and NUM_ARGS 32-bit kernel argument registers, with byte-strobe writes. It sits between the `s_axi_control` port of the kernel top level and the accelerator core. It replaces per-design hand-wired CSR logic.

## Interface
Parameters:
- NUM_ARGS, 4, number of 32-bit argument registers (1..64)
- ADDR_W, 12, AXI-Lite address width; must satisfy 0x10 + 4*NUM_ARGS <= 2^ADDR_W

Ports:
- clk  in  1  kernel clock (single clock domain)
- reset  in  1  asynchronous, active-high reset
- csr_AWVALID/csr_AWREADY  in/out  1  write-address handshake
- csr_AWADDR  in  ADDR_W  write address
- csr_WVALID/csr_WREADY  in/out  1  write-data handshake
- csr_WDATA  in  32  write data
- csr_WSTRB  in  4  byte strobes
- csr_BVALID/csr_BREADY  out/in  1  write-response handshake
- csr_BRESP  out  2  always 2'b00 (OKAY)
- csr_ARVALID/csr_ARREADY  in/out  1  read-address handshake
- csr_ARADDR  in  ADDR_W  read address
- csr_RVALID/csr_RREADY  out/in  1  read-data handshake
- csr_RDATA  out  32  read data
- csr_RRESP  out  2  always 2'b00
- ap_start  out  1  start request to the core
- ap_ready  in  1  single-cycle pulse: core accepted its inputs
- ap_done  in  1  single-cycle pulse: core finished
- ap_idle  in  1  level: core idle
- args  out  32*NUM_ARGS  argument registers; arg k is at bits [32k+31:32k]
- interrupt  out  1  level interrupt (see Configuration)

## Operation
- Address decode uses AxADDR[ADDR_W-1:2]; bits [1:0] are ignored.
- Register map:
  - 0x00 CTRL: bit0 ap_start (RW1S), bit1 done (RO, clear-on-read), bit2 ap_idle (RO live), bit3 ready (RO, clear-on-read), bit7 auto_restart (RW).
  - 0x04 GIE, 0x08 IER, 0x0C ISR (these three exist only with the macro).
  - 0x10+4k: arg k (RW, honours WSTRB).
- ap_start:
  - Set by a write of 1 to CTRL bit0; writing 0 has no effect.
  - Cleared on ap_ready unless auto_restart=1, in which case it stays 1.
- done/ready sticky bits:
  - Set by the ap_done/ap_ready pulses.
  - Cleared by a CTRL read handshake. The read returns the pre-clear value.
  - A set in the same cycle as the clear wins: the bit stays 1.
- Out-of-range writes are discarded with BRESP OKAY. Out-of-range reads return 0 with OKAY.
- Write channel:
  - AW and W are accepted independently, each into a one-entry holding register.
  - csr_AWREADY = !aw_held && !csr_BVALID; csr_WREADY = !w_held && !csr_BVALID.
  - Once both are held, the register write is committed and BVALID is raised. Both holding registers clear at that point.
- Read channel: csr_ARREADY = !csr_RVALID. RDATA is registered at the AR handshake and held stable until the R handshake.

## Timing
- Reset values:
  - All AXI READY outputs and the holding flags: 0, so READYs are 0 during reset and rise the first cycle after.
  - BVALID=0, RVALID=0, RDATA=0, ap_start=0, sticky bits 0, auto_restart=0, args=0, interrupt=0.
- Write latency: BVALID rises and the register updates on the edge after the later of the AW/W handshakes (1 cycle when both are in the same cycle). The next AW/W is accepted after the B handshake.
- Read latency: RVALID rises on the edge after the AR handshake. Back-to-back reads run at 1 per 2 cycles.
- ap_start reflects a CTRL write on the same edge as BVALID.
- Concurrent ap_ready and a write of 1 to CTRL bit0: ap_start stays 1.
- Reset asserted mid-transaction: all state is dropped immediately and no response is issued.

## Configuration
- SDACCEL_CTRL_IRQ_EN defined:
  - GIE bit0, IER bits[1:0] (0=done, 1=ready) and ISR bits[1:0] are implemented.
  - An ISR bit is set when its event occurs and IER enables it. Writing 1 to an ISR bit toggles it. Set wins over toggle in the same cycle.
  - interrupt = GIE & |ISR, registered.
- Undefined: 0x04–0x0C read 0 and ignore writes; interrupt is tied to 0.

## Structure
- Package sdaccel_ctrl_pkg holds the register offsets, CTRL/IER/ISR bit indices and the RESP_OKAY constant.
- Sub-module sdaccel_ap_ctrl holds the ap_start, auto_restart, done/ready sticky and ISR state. The top level holds the AXI-Lite channels and the argument registers.

## Test plan
- Write 0xDEADBEEF to 0x14 with WSTRB=4'b0011 after reset -> arg1 reads 0x0000BEEF; args[63:32] equals 0x0000BEEF.
- Issue W two cycles before AW to 0x10 -> exactly one BVALID, rising 1 cycle after the AW handshake. Hold BREADY=0 for 3 cycles -> AWREADY/WREADY stay 0.
- Write CTRL=0x1, then pulse ap_ready, then ap_done -> ap_start falls the cycle after ap_ready. CTRL reads 0x0A (done, ready, ap_idle=0), then reads 0x00.
- Write CTRL=0x81 and pulse ap_ready 3 times -> ap_start stays 1 throughout.
- With the macro: write GIE=1 and IER=1, pulse ap_done -> interrupt=1 the next cycle. Write ISR=1 -> interrupt=0.
- Read 0x200 with NUM_ARGS=4 -> RDATA=0, RRESP=0. Assert reset while AW is held -> BVALID never rises.
